// File: rtl/sr_excitation_driver.sv
// sr_excitation_driver
//   Drives an external SR flip-flop toward a requested next state. A target
//   bit is accepted over a valid/ready handshake. S/R come from the
//   excitation table applied to the fed-back Q. One cycle after the
//   flip-flop has sampled S/R, Q is compared with the target, and the block
//   reports completion and any mismatch.
//
//   Optional feature (macro SR_ERR_CNT_EN): adds a saturating err_cnt output.
//
// Parameters
//   CNT_W        width of xfer_cnt / err_cnt
//   FORCE_DRIVE  1: pulse S (target 1) or R (target 0) even when target == Q
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   tgt_valid    target bit offered
//   tgt_bit      requested next Q
//   tgt_ready    block can accept a target (IDLE only, from state)
//   s, r         registered set/reset to the flip-flop
//   q_fb         q fed back from the flip-flop
//   done_valid   one-cycle completion pulse
//   mismatch     q_fb != target at completion, held until next done_valid
//   xfer_cnt     completed transfers, wrapping
//   err_cnt      (SR_ERR_CNT_EN only) mismatching transfers, saturating
module sr_excitation_driver #(
    parameter int unsigned CNT_W       = 8,
    parameter bit          FORCE_DRIVE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    input  logic             tgt_bit,
    output logic             tgt_ready,
    output logic             s,
    output logic             r,
    input  logic             q_fb,
    output logic             done_valid,
    output logic             mismatch,
`ifdef SR_ERR_CNT_EN
    output logic [CNT_W-1:0] err_cnt,
`endif
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic               tgt_q, tgt_nxt;
    logic               s_nxt, r_nxt;
    logic               done_nxt, mis_nxt;
    logic [CNT_W-1:0]   xfer_nxt;
`ifdef SR_ERR_CNT_EN
    logic [CNT_W-1:0]   err_nxt;
`endif

    assign tgt_ready = (state == IDLE);

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            tgt_q      <= 1'b0;
            s          <= 1'b0;
            r          <= 1'b0;
            done_valid <= 1'b0;
            mismatch   <= 1'b0;
            xfer_cnt   <= '0;
`ifdef SR_ERR_CNT_EN
            err_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            tgt_q      <= tgt_nxt;
            s          <= s_nxt;
            r          <= r_nxt;
            done_valid <= done_nxt;
            mismatch   <= mis_nxt;
            xfer_cnt   <= xfer_nxt;
`ifdef SR_ERR_CNT_EN
            err_cnt    <= err_nxt;
`endif
        end
    end

    // Next state and next output values; s/r default to hold (0,0)
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_q;
        s_nxt     = 1'b0;
        r_nxt     = 1'b0;
        done_nxt  = 1'b0;
        mis_nxt   = mismatch;
        xfer_nxt  = xfer_cnt;
`ifdef SR_ERR_CNT_EN
        err_nxt   = err_cnt;
`endif
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_nxt   = tgt_bit;
                    state_nxt = DRIVE;
                    // s and r are mutually exclusive in every branch
                    if (tgt_bit && !q_fb) begin
                        s_nxt = 1'b1;
                    end else if (!tgt_bit && q_fb) begin
                        r_nxt = 1'b1;
                    end else if (FORCE_DRIVE) begin
                        s_nxt = tgt_bit;
                        r_nxt = !tgt_bit;
                    end
                end
            end
            DRIVE: begin
                state_nxt = CHECK;
            end
            CHECK: begin
                mis_nxt   = (q_fb != tgt_q);
                done_nxt  = 1'b1;
                xfer_nxt  = xfer_cnt + CNT_W'(1);
                state_nxt = IDLE;
`ifdef SR_ERR_CNT_EN
                if ((q_fb != tgt_q) && (err_cnt != {CNT_W{1'b1}})) begin
                    err_nxt = err_cnt + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sr_excitation_driver.sv
// Self-checking bench for sr_excitation_driver. A behavioural SR flip-flop
// closes the loop from s/r back to q_fb. A second instance built with
// FORCE_DRIVE=1 shares the same stimulus and feedback.
module tb_sr_excitation_driver;

    localparam int unsigned CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             tgt_valid;
    logic             tgt_bit;
    logic             q_fb;
    logic             tgt_ready, s, r, done_valid, mismatch;
    logic [CNT_W-1:0] xfer_cnt;
    logic             tgt_ready_f, s_f, r_f, done_valid_f, mismatch_f;
    logic [CNT_W-1:0] xfer_cnt_f;
`ifdef SR_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt, err_cnt_f;
`endif

    logic             q_ff  = 1'b0;
    logic             fault = 1'b0;
    logic [CNT_W-1:0] exp_cnt = '0;
    int               n_checks = 0;
    int               n_errors = 0;
    int               sr_both  = 0;

    always #5 clk = ~clk;

    // Behavioural SR flip-flop; fault pins its q output low
    always @(posedge clk) begin
        if (s)      q_ff <= 1'b1;
        else if (r) q_ff <= 1'b0;
    end
    assign q_fb = fault ? 1'b0 : q_ff;

    sr_excitation_driver #(.CNT_W(CNT_W), .FORCE_DRIVE(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready), .s(s), .r(r), .q_fb(q_fb),
        .done_valid(done_valid), .mismatch(mismatch),
`ifdef SR_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .xfer_cnt(xfer_cnt)
    );

    sr_excitation_driver #(.CNT_W(CNT_W), .FORCE_DRIVE(1'b1)) dut_f (
        .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid), .tgt_bit(tgt_bit),
        .tgt_ready(tgt_ready_f), .s(s_f), .r(r_f), .q_fb(q_fb),
        .done_valid(done_valid_f), .mismatch(mismatch_f),
`ifdef SR_ERR_CNT_EN
        .err_cnt(err_cnt_f),
`endif
        .xfer_cnt(xfer_cnt_f)
    );

    // Forbidden SR input watch, every half cycle including reset
    always @(clk) begin
        if ((s && r) || (s_f && r_f)) sr_both++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One complete transfer, entered at a negedge; returns at the negedge
    // after the completion edge
    task automatic do_xfer(input logic b, input logic es, input logic er,
                           input logic efs, input logic efr, input logic emis);
        int n = 0;
        while (!tgt_ready && n < 5) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", 32'(tgt_ready), 32'd1);
        tgt_valid = 1'b1;
        tgt_bit   = b;
        @(negedge clk);
        tgt_valid = 1'b0;
        check("drive_s", 32'(s), 32'(es));
        check("drive_r", 32'(r), 32'(er));
        check("drive_s_f", 32'(s_f), 32'(efs));
        check("drive_r_f", 32'(r_f), 32'(efr));
        check("drive_busy", 32'(tgt_ready), 32'd0);
        @(negedge clk);
        check("check_sr", {30'd0, s, r}, 32'd0);
        check("check_nodone", 32'(done_valid), 32'd0);
        @(negedge clk);
        exp_cnt = exp_cnt + CNT_W'(1);
        check("done", 32'(done_valid), 32'd1);
        check("mismatch", 32'(mismatch), 32'(emis));
        check("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        check("ready_again", 32'(tgt_ready), 32'd1);
    endtask

    initial begin
        int  n;
        logic seen;
        logic [2:0] seq;
        rst_n     = 1'b0;
        tgt_valid = 1'b0;
        tgt_bit   = 1'b0;

        // Reset
        repeat (2) @(negedge clk);
        check("rst_sr", {30'd0, s, r}, 32'd0);
        check("rst_ready", 32'(tgt_ready), 32'd1);
        check("rst_done", 32'(done_valid), 32'd0);
        check("rst_mis", 32'(mismatch), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Set, reset, hold (both directions)
        do_xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("q_after_set", 32'(q_ff), 32'd1);
        do_xfer(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        check("q_after_rst", 32'(q_ff), 32'd0);
        do_xfer(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("q_hold0", 32'(q_ff), 32'd0);
        do_xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_xfer(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("q_hold1", 32'(q_ff), 32'd1);

        // Stuck-at-0 feedback: first fault, then run to 300 (counter wraps)
        fault = 1'b1;
        do_xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
`ifdef SR_ERR_CNT_EN
        check("err_cnt_1", 32'(err_cnt), 32'd1);
`endif
        for (int i = 1; i < 300; i++) begin
            do_xfer(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        end
`ifdef SR_ERR_CNT_EN
        check("err_cnt_sat", 32'(err_cnt), 32'd255);
        check("err_cnt_sat_f", 32'(err_cnt_f), 32'd255);
`endif
        check("xfer_wrap", 32'(xfer_cnt), 32'd49); // 5 + 300 = 305 mod 256
        fault = 1'b0;
        do_xfer(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("mis_clears", 32'(mismatch), 32'd0);

        // Back-to-back 1,0,1 with tgt_valid held high
        seq = 3'b101;
        tgt_valid = 1'b1;
        for (int i = 2; i >= 0; i--) begin
            tgt_bit = seq[i];
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done_valid && n < 6);
            check("b2b_latency", 32'(n), 32'd3);
            check("b2b_mis", 32'(mismatch), 32'd0);
        end
        tgt_valid = 1'b0;
        exp_cnt = exp_cnt + CNT_W'(3);
        check("b2b_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        check("b2b_q", 32'(q_ff), 32'd1);

        // Async reset while in DRIVE
        do_xfer(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tgt_valid = 1'b1;
        tgt_bit   = 1'b1;
        @(negedge clk);
        tgt_valid = 1'b0;
        check("pre_rst_s", 32'(s), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_cnt", 32'(xfer_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_valid) seen = 1'b1;
        end
        check("midrst_nodone", 32'(seen), 32'd0);
        check("midrst_q", 32'(q_ff), 32'd0);

        check("sr_never_both", 32'(sr_both), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
